// File: rtl/ad_ip_jesd204_tpl_dac_datagen.sv
// Per-channel DAC sample source. It selects DDS, DMA, constant pattern, PN7, PN15,
// ramp or zeros and registers one word of SAMPLES 16-bit samples per link_clk.
// Ports:
//   link_clk, link_resetn           clock, async active-low reset
//   dac_valid                       framer consumes a word; all state advances only then
//   dac_sync                        restart pulse for every generator
//   dac_data_sel                    source select (0 DDS, 1 pattern, 2 DMA, 6 PN7, 7 PN15, 11 ramp)
//   dac_dds_format                  0 = offset binary (flip sample MSB), 1 = two's complement
//   dac_pat_data_0/1                pattern words for even/odd samples
//   dds_data, dma_data, dma_valid   upstream sample sources
//   dma_ready                       combinational: DMA word consumed this cycle
//   dac_data                        registered output word, sample k at [16k+15:16k]
//   dac_dunf                        registered one-cycle DMA underflow flag
module ad_ip_jesd204_tpl_dac_datagen #(
    parameter int unsigned SAMPLES = 4
) (
    input  logic                  link_clk,
    input  logic                  link_resetn,
    input  logic                  dac_valid,
    input  logic                  dac_sync,
    input  logic [3:0]            dac_data_sel,
    input  logic                  dac_dds_format,
    input  logic [15:0]           dac_pat_data_0,
    input  logic [15:0]           dac_pat_data_1,
    input  logic [16*SAMPLES-1:0] dds_data,
    input  logic [16*SAMPLES-1:0] dma_data,
    input  logic                  dma_valid,
    output logic                  dma_ready,
    output logic [16*SAMPLES-1:0] dac_data,
    output logic                  dac_dunf
);

    localparam int unsigned DW = 16 * SAMPLES;

    localparam logic [3:0] SEL_DDS  = 4'd0;
    localparam logic [3:0] SEL_PAT  = 4'd1;
    localparam logic [3:0] SEL_DMA  = 4'd2;
    localparam logic [3:0] SEL_PN7  = 4'd6;
    localparam logic [3:0] SEL_PN15 = 4'd7;
    localparam logic [3:0] SEL_RAMP = 4'd11;

    logic [6:0]    pn7_state;
    logic [14:0]   pn15_state;
    logic [15:0]   ramp_base;
    logic [3:0]    sel_prev;

    logic          restart;
    logic [6:0]    pn7_eff;
    logic [6:0]    pn7_adv;
    logic [14:0]   pn15_eff;
    logic [14:0]   pn15_adv;
    logic [15:0]   ramp_eff;
    logic [DW-1:0] pn7_word;
    logic [DW-1:0] pn15_word;
    logic [DW-1:0] word;
    logic          fmt_inv;

    // Unrolled PN7 (x^7+x^6+1): 16 bits per sample, first bit at sample bit 15.
    function automatic void pn7_gen(input logic [6:0] s, output logic [DW-1:0] w,
                                    output logic [6:0] ns);
        logic fb;
        ns = s;
        w  = '0;
        for (int unsigned i = 0; i < DW; i++) begin
            fb = ns[6] ^ ns[5];
            ns = {ns[5:0], fb};
            w[(i / 16) * 16 + 15 - (i % 16)] = fb;
        end
    endfunction

    // Unrolled PN15 (x^15+x^14+1), same bit ordering as PN7.
    function automatic void pn15_gen(input logic [14:0] s, output logic [DW-1:0] w,
                                     output logic [14:0] ns);
        logic fb;
        ns = s;
        w  = '0;
        for (int unsigned i = 0; i < DW; i++) begin
            fb = ns[14] ^ ns[13];
            ns = {ns[13:0], fb};
            w[(i / 16) * 16 + 15 - (i % 16)] = fb;
        end
    endfunction

    assign dma_ready = dac_valid & (dac_data_sel == SEL_DMA);

    // Source mux; a restart cycle already emits the first word of the new sequence.
    always_comb begin
        restart   = dac_sync | (dac_data_sel != sel_prev);
        pn7_eff   = restart ? 7'h7F : pn7_state;
        pn15_eff  = restart ? 15'h7FFF : pn15_state;
        ramp_eff  = restart ? 16'h0000 : ramp_base;
        pn7_word  = '0;
        pn7_adv   = pn7_eff;
        pn15_word = '0;
        pn15_adv  = pn15_eff;
        word      = '0;
        fmt_inv   = 1'b0;

        pn7_gen(pn7_eff, pn7_word, pn7_adv);
        pn15_gen(pn15_eff, pn15_word, pn15_adv);

        case (dac_data_sel)
            SEL_DDS: begin
                word    = dds_data;
                fmt_inv = 1'b1;
            end
            SEL_PAT: begin
                for (int unsigned k = 0; k < SAMPLES; k++) begin
                    word[16*k +: 16] = (k % 2 == 0) ? dac_pat_data_0 : dac_pat_data_1;
                end
                fmt_inv = 1'b1;
            end
            SEL_DMA: begin
                // Underflow emits a true zero word, never format-adjusted.
                if (dma_valid) begin
                    word    = dma_data;
                    fmt_inv = 1'b1;
                end
            end
            SEL_PN7:  word = pn7_word;
            SEL_PN15: word = pn15_word;
            SEL_RAMP: begin
                for (int unsigned k = 0; k < SAMPLES; k++) begin
                    word[16*k +: 16] = ramp_eff + 16'(k);
                end
                fmt_inv = 1'b1;
            end
            default: word = '0;
        endcase

        if (fmt_inv && !dac_dds_format) begin
            for (int unsigned k = 0; k < SAMPLES; k++) begin
                word[16*k + 15] = ~word[16*k + 15];
            end
        end
    end

    // Generator state and output registers; nothing advances without dac_valid.
    always_ff @(posedge link_clk or negedge link_resetn) begin
        if (!link_resetn) begin
            pn7_state  <= 7'h7F;
            pn15_state <= 15'h7FFF;
            ramp_base  <= 16'h0000;
            sel_prev   <= 4'd0;
            dac_data   <= '0;
            dac_dunf   <= 1'b0;
        end else begin
            sel_prev <= dac_data_sel;
            dac_dunf <= dac_valid & (dac_data_sel == SEL_DMA) & ~dma_valid;
            if (dac_valid) begin
                dac_data   <= word;
                pn7_state  <= pn7_adv;
                pn15_state <= pn15_adv;
                ramp_base  <= ramp_eff + 16'(SAMPLES);
            end else begin
                pn7_state  <= pn7_eff;
                pn15_state <= pn15_eff;
                ramp_base  <= ramp_eff;
            end
        end
    end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_datagen.sv
// Scoreboard bench for ad_ip_jesd204_tpl_dac_datagen (SAMPLES = 4).
// Stimulus drives on the falling edge and queues the expected registered response;
// the monitor pops one entry per rising edge and compares shortly after it.
`timescale 1ns/1ps
module tb_ad_ip_jesd204_tpl_dac_datagen;

    localparam int unsigned SAMPLES = 4;
    localparam int unsigned DW      = 16 * SAMPLES;

    logic          link_clk = 1'b0;
    logic          link_resetn = 1'b0;
    logic          dac_valid = 1'b0;
    logic          dac_sync = 1'b0;
    logic [3:0]    dac_data_sel = 4'd0;
    logic          dac_dds_format = 1'b1;
    logic [15:0]   dac_pat_data_0 = 16'h1234;
    logic [15:0]   dac_pat_data_1 = 16'hABCD;
    logic [DW-1:0] dds_data = 64'h0123_4567_89AB_CDEF;
    logic [DW-1:0] dma_data = 64'hFEDC_BA98_7654_3210;
    logic          dma_valid = 1'b1;
    logic          dma_ready;
    logic [DW-1:0] dac_data;
    logic          dac_dunf;

    ad_ip_jesd204_tpl_dac_datagen #(.SAMPLES(SAMPLES)) dut (
        .link_clk       (link_clk),
        .link_resetn    (link_resetn),
        .dac_valid      (dac_valid),
        .dac_sync       (dac_sync),
        .dac_data_sel   (dac_data_sel),
        .dac_dds_format (dac_dds_format),
        .dac_pat_data_0 (dac_pat_data_0),
        .dac_pat_data_1 (dac_pat_data_1),
        .dds_data       (dds_data),
        .dma_data       (dma_data),
        .dma_valid      (dma_valid),
        .dma_ready      (dma_ready),
        .dac_data       (dac_data),
        .dac_dunf       (dac_dunf)
    );

    always #5 link_clk = ~link_clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          dunf;
        logic          ready;
        string         tag;
    } exp_t;

    exp_t          sb_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] last_exp = '0;
    logic          pn7_seq[127];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One falling-edge stimulus cycle plus its queued expectation.
    task automatic step(input logic v, input logic [3:0] sel, input logic sync, input logic dv,
                        input logic fmt, input logic [DW-1:0] exp_w, input string tag);
        exp_t e;
        @(negedge link_clk);
        dac_valid      = v;
        dac_data_sel   = sel;
        dac_sync       = sync;
        dma_valid      = dv;
        dac_dds_format = fmt;
        if (v) last_exp = exp_w;
        e.data  = last_exp;
        e.dunf  = v && (sel == 4'd2) && !dv;
        e.ready = v && (sel == 4'd2);
        e.tag   = tag;
        sb_q.push_back(e);
    endtask

    function automatic logic [DW-1:0] ramp_word(input logic [15:0] base);
        logic [DW-1:0] w;
        for (int k = 0; k < SAMPLES; k++) w[16*k +: 16] = base + 16'(k);
        return w;
    endfunction

    function automatic logic [DW-1:0] pn7_ref(input int n);
        logic [DW-1:0] w;
        for (int k = 0; k < SAMPLES; k++)
            for (int j = 0; j < 16; j++)
                w[16*k + 15 - j] = pn7_seq[(64*n + 16*k + j) % 127];
        return w;
    endfunction

    // Bit-serial PN15 reference, one bit at a time in sample order.
    function automatic void pn15_ref(input logic [14:0] s, output logic [DW-1:0] w,
                                     output logic [14:0] ns);
        int   pos;
        logic fb;
        ns  = s;
        pos = 0;
        w   = '0;
        for (int k = 0; k < SAMPLES; k++) begin
            for (int j = 15; j >= 0; j--) begin
                fb = ns[14] ^ ns[13];
                ns = {ns[13:0], fb};
                w[16*k + j] = fb;
                pos++;
            end
        end
    endfunction

    // Monitor: one scoreboard entry per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge link_clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                #1;
                check({e.tag, ".data"}, dac_data, e.data);
                check({e.tag, ".dunf"}, DW'(dac_dunf), DW'(e.dunf));
                check({e.tag, ".ready"}, DW'(dma_ready), DW'(e.ready));
            end
        end
    end

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        logic [DW-1:0] w;
        logic [DW-1:0] w0;
        logic [DW-1:0] pw[0:10];
        logic [14:0]   s15;
        logic [6:0]    s7;
        logic          fb;

        s7 = 7'h7F;
        for (int i = 0; i < 127; i++) begin
            fb = s7[6] ^ s7[5];
            s7 = {s7[5:0], fb};
            pn7_seq[i] = fb;
        end

        // Reset state
        repeat (2) @(negedge link_clk);
        check("rst.data", dac_data, '0);
        check("rst.dunf", DW'(dac_dunf), '0);
        check("rst.ready", DW'(dma_ready), '0);
        @(negedge link_clk);
        link_resetn = 1'b1;

        // DDS with both formats
        step(1, 4'd0, 0, 1, 0, 64'h8123_C567_09AB_4DEF, "dds_fmt0");
        step(1, 4'd0, 0, 1, 1, 64'h0123_4567_89AB_CDEF, "dds_fmt1");

        // Constant pattern, offset binary
        for (int i = 0; i < 3; i++) step(1, 4'd1, 0, 1, 0, 64'h2BCD_9234_2BCD_9234, "pat");

        // Ramp with a valid gap
        step(1, 4'd11, 0, 1, 1, 64'h0003_0002_0001_0000, "ramp0");
        step(1, 4'd11, 0, 1, 1, 64'h0007_0006_0005_0004, "ramp1");
        for (int n = 2; n < 6; n++) step(1, 4'd11, 0, 1, 1, ramp_word(16'(4*n)), "ramp");
        step(0, 4'd11, 0, 1, 1, '0, "ramp_hold");
        step(0, 4'd11, 0, 1, 1, '0, "ramp_hold");
        step(1, 4'd11, 0, 1, 1, 64'h001B_001A_0019_0018, "ramp6");

        // Asynchronous reset mid-ramp
        @(negedge link_clk);
        dac_valid = 1'b0;
        begin
            exp_t e;
            e.data = '0; e.dunf = 1'b0; e.ready = 1'b0; e.tag = "in_rst";
            sb_q.push_back(e);
        end
        last_exp = '0;
        #2 link_resetn = 1'b0;
        #1;
        check("async_rst.data", dac_data, '0);
        @(negedge link_clk);
        link_resetn = 1'b1;

        // Ramp restarts, then runs through the 16-bit wrap
        step(1, 4'd11, 0, 1, 1, 64'h0003_0002_0001_0000, "ramp_after_rst");
        for (int n = 1; n <= 16384; n++) begin
            if (n == 16383)      w = 64'hFFFF_FFFE_FFFD_FFFC;
            else if (n == 16384) w = 64'h0003_0002_0001_0000;
            else                 w = ramp_word(16'(4*n));
            step(1, 4'd11, 0, 1, 1, w, (n >= 16383) ? "ramp_wrap" : "ramp_run");
        end
        step(1, 4'd11, 0, 1, 0, 64'h8007_8006_8005_8004, "ramp_fmt0");

        // PN7, offset-binary format must not touch PN words
        for (int n = 0; n < 40; n++) step(1, 4'd6, 0, 1, 0, pn7_ref(n), "pn7");

        // PN15 with sync restart and valid gap
        s15 = 15'h7FFF;
        for (int n = 0; n <= 10; n++) begin
            pn15_ref(s15, pw[n], s15);
            step(1, 4'd7, 0, 1, 1, pw[n], "pn15");
        end
        w0 = pw[0];
        pn15_ref(15'h7FFF, w, s15);
        step(1, 4'd7, 1, 1, 1, w0, "pn15_sync");
        pn15_ref(s15, w, s15);
        step(1, 4'd7, 0, 1, 1, w, "pn15_after_sync");
        for (int i = 0; i < 3; i++) step(0, 4'd7, 0, 1, 1, '0, "pn15_frozen");
        pn15_ref(s15, w, s15);
        step(1, 4'd7, 0, 1, 1, w, "pn15_resume");
        pn15_ref(s15, w, s15);
        step(1, 4'd7, 0, 1, 1, w, "pn15_resume");

        // DMA handshake, underflow, zeros
        step(1, 4'd2, 0, 1, 1, 64'hFEDC_BA98_7654_3210, "dma");
        step(1, 4'd2, 0, 0, 1, '0, "dma_unf1");
        step(1, 4'd2, 0, 0, 0, '0, "dma_unf2");
        step(0, 4'd2, 0, 0, 1, '0, "dma_idle");
        step(1, 4'd2, 0, 1, 0, 64'h7EDC_3A98_F654_B210, "dma_fmt0");
        step(1, 4'd3, 0, 1, 0, '0, "zero_sel3");
        step(1, 4'd3, 0, 0, 1, '0, "zero_sel3");
        step(1, 4'd5, 0, 1, 0, '0, "zero_other");
        step(0, 4'd5, 0, 1, 0, '0, "end");

        repeat (3) @(negedge link_clk);
        check("sb_drain", DW'(sb_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
